// File: rtl/saph_span_walker.sv
// Span pixel walker: steps an edge incrementer per pixel, emits covered fragments.
// Ports: span_* request in; inc_* incrementer ctrl/data; frag_* out; span_done pulse.
// Option: SAPH_WALKER_EARLY_EXIT_EN ends a span on the first miss after a hit.
module saph_span_walker #(
  parameter int EDGES = 3,
  parameter int XW    = 11,
  parameter int YW    = 11
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        span_valid,
  output logic                        span_ready,
  input  logic [XW-1:0]               span_x,
  input  logic [YW-1:0]               span_y,
  input  logic [XW-1:0]               span_len,
  input  logic [EDGES-1:0][31:0]      span_init,
  input  logic [EDGES-1:0][31:0]      span_inc,
  output logic                        inc_latch,
  output logic                        inc_count,
  input  logic                        inc_ready,
  output logic [EDGES-1:0][31:0]      inc_init,
  output logic [EDGES-1:0][31:0]      inc_inc,
  input  logic [EDGES-1:0][31:0]      inc_cur,
  output logic                        frag_valid,
  input  logic                        frag_ready,
  output logic [XW-1:0]               frag_x,
  output logic [YW-1:0]               frag_y,
  output logic                        span_done
);

  typedef enum logic [2:0] {
    IDLE, LATCH, TEST, EMIT, STEP, WAIT, DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [XW-1:0]            x_q, x_d;
  logic [YW-1:0]            y_q, y_d;
  logic [XW-1:0]            rem_q, rem_d;
  logic [XW-1:0]            fx_q, fx_d;
  logic [YW-1:0]            fy_q, fy_d;
  logic [EDGES-1:0][31:0]   init_q, init_d;
  logic [EDGES-1:0][31:0]   inc_q, inc_d;
  logic                     covered;
  logic                     last;
`ifdef SAPH_WALKER_EARLY_EXIT_EN
  logic                     seen_q, seen_d;
`endif

  // -0.0 has its sign bit set, so it is treated as outside the edge.
  always_comb begin
    covered = 1'b1;
    for (int i = 0; i < EDGES; i++) begin
      if (inc_cur[i][31]) covered = 1'b0;
    end
  end

  assign last = (rem_q == XW'(1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    rem_d   = rem_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    init_d  = init_q;
    inc_d   = inc_q;
`ifdef SAPH_WALKER_EARLY_EXIT_EN
    seen_d  = seen_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (span_valid) begin
          x_d    = span_x;
          y_d    = span_y;
          rem_d  = span_len;
          init_d = span_init;
          inc_d  = span_inc;
`ifdef SAPH_WALKER_EARLY_EXIT_EN
          seen_d = 1'b0;
`endif
          state_d = (span_len == '0) ? DONE : LATCH;
        end
      end
      LATCH: state_d = TEST;
      TEST: begin
        if (covered) begin
          fx_d    = x_q;
          fy_d    = y_q;
`ifdef SAPH_WALKER_EARLY_EXIT_EN
          seen_d  = 1'b1;
`endif
          state_d = EMIT;
`ifdef SAPH_WALKER_EARLY_EXIT_EN
        end else if (seen_q) begin
          state_d = DONE;
`endif
        end else begin
          state_d = last ? DONE : STEP;
        end
      end
      EMIT: begin
        if (frag_ready) state_d = last ? DONE : STEP;
      end
      STEP: begin
        x_d     = x_q + XW'(1);
        rem_d   = rem_q - XW'(1);
        state_d = inc_ready ? TEST : WAIT;
      end
      WAIT: begin
        if (inc_ready) state_d = TEST;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      rem_q   <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      init_q  <= '0;
      inc_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rem_q   <= rem_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      init_q  <= init_d;
      inc_q   <= inc_d;
    end
  end

`ifdef SAPH_WALKER_EARLY_EXIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seen_q <= 1'b0;
    else        seen_q <= seen_d;
  end
`endif

  assign span_ready = (state_q == IDLE);
  assign inc_latch  = (state_q == LATCH);
  assign inc_count  = (state_q == STEP);
  assign frag_valid = (state_q == EMIT);
  assign span_done  = (state_q == DONE);
  assign frag_x     = fx_q;
  assign frag_y     = fy_q;
  assign inc_init   = init_q;
  assign inc_inc    = inc_q;

endmodule

// File: tb/tb_saph_span_walker.sv
// Directed bench for saph_span_walker with a behavioural float incrementer.
// Fast (1-cycle) and slow (ready-gated) incrementer modes; fragment scoreboard.
module tb_saph_span_walker;

  localparam int E  = 3;
  localparam int XW = 11;
  localparam int YW = 11;

  logic                 clk = 0;
  logic                 rst_n = 0;
  logic                 span_valid = 0;
  logic                 span_ready;
  logic [XW-1:0]        span_x = 0;
  logic [YW-1:0]        span_y = 0;
  logic [XW-1:0]        span_len = 0;
  logic [E-1:0][31:0]   span_init = 0;
  logic [E-1:0][31:0]   span_inc = 0;
  logic                 inc_latch, inc_count, inc_ready;
  logic [E-1:0][31:0]   inc_init, inc_inc;
  logic [E-1:0][31:0]   cur;
  logic                 frag_valid;
  logic                 frag_ready = 1;
  logic [XW-1:0]        frag_x;
  logic [YW-1:0]        frag_y;
  logic                 span_done;

  saph_span_walker #(.EDGES(E), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rst_n(rst_n),
    .span_valid(span_valid), .span_ready(span_ready),
    .span_x(span_x), .span_y(span_y), .span_len(span_len),
    .span_init(span_init), .span_inc(span_inc),
    .inc_latch(inc_latch), .inc_count(inc_count),
    .inc_ready(inc_ready),
    .inc_init(inc_init), .inc_inc(inc_inc), .inc_cur(cur),
    .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_x(frag_x), .frag_y(frag_y), .span_done(span_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r2f(real v);
    logic s;
    real  a;
    int   e;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((a - 1.0) * 8388608.0))};
  endfunction

  function automatic real f2r(logic [31:0] b);
    real a;
    int  e;
    if (b[30:0] == 0) return 0.0;
    a = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin a = a * 2.0; e--; end
    while (e < 0) begin a = a / 2.0; e++; end
    return b[31] ? -a : a;
  endfunction

  // Behavioural incrementer: slow mode holds ready low while busy.
  logic slow = 0;
  int   busy;

  function automatic logic [E-1:0][31:0] add_all(
      logic [E-1:0][31:0] c, logic [E-1:0][31:0] d);
    logic [E-1:0][31:0] r;
    for (int i = 0; i < E; i++) r[i] = r2f(f2r(c[i]) + f2r(d[i]));
    return r;
  endfunction

  assign inc_ready = !(slow && (inc_count || busy != 0));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 0;
      cur  <= '0;
    end else if (inc_latch) begin
      cur <= inc_init;
    end else if (inc_count) begin
      if (slow) busy <= 2;
      else      cur  <= add_all(cur, inc_inc);
    end else if (busy != 0) begin
      busy <= busy - 1;
      if (busy == 1) cur <= add_all(cur, inc_inc);
    end
  end

  // Monitor + fragment-ready driver, all on the falling edge.
  int              fr_mode = 0;
  int              cyc = 0;
  int              n_latch = 0, n_count = 0, n_done = 0;
  logic [XW-1:0]   got_x[$];
  logic [YW-1:0]   got_y[$];
  logic            pv = 0, pr = 0;
  logic [XW-1:0]   px;
  logic [YW-1:0]   py;

  initial forever begin
    @(negedge clk);
    cyc++;
    frag_ready = (fr_mode == 0) ? 1'b1 :
                 (fr_mode == 1) ? (cyc % 3 == 0) : 1'b0;
    if (!rst_n) begin
      pv = 0;
    end else begin
      if (pv && !pr) begin
        check("hold_v", 32'(frag_valid), 32'd1);
        check("hold_x", 32'(frag_x), 32'(px));
        check("hold_y", 32'(frag_y), 32'(py));
      end
      if (inc_latch && inc_count) check("excl", 32'd1, 32'd0);
      if (inc_latch) n_latch++;
      if (inc_count) n_count++;
      if (span_done) n_done++;
      if (frag_valid && frag_ready) begin
        got_x.push_back(frag_x);
        got_y.push_back(frag_y);
      end
      pv = frag_valid;
      pr = frag_ready;
      px = frag_x;
      py = frag_y;
    end
  end

  int l0, c0, d0;

  task automatic start_span(logic [XW-1:0] x, logic [YW-1:0] y,
                            logic [XW-1:0] len,
                            logic [E-1:0][31:0] ini,
                            logic [E-1:0][31:0] inc);
    int t = 0;
    while (!span_ready && t < 200) begin @(negedge clk); t++; end
    if (!span_ready) check("ready_to", 32'd0, 32'd1);
    got_x.delete();
    got_y.delete();
    l0 = n_latch; c0 = n_count; d0 = n_done;
    span_x = x; span_y = y; span_len = len;
    span_init = ini; span_inc = inc;
    span_valid = 1;
    @(negedge clk);
    span_valid = 0;
    span_x = '1; span_len = '1; span_init = '1; span_inc = '1;
  endtask

  task automatic wait_done();
    int t = 0;
    while (n_done == d0 && t < 2000) begin @(negedge clk); t++; end
    if (n_done == d0) check("done_to", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    check("done_once", 32'(n_done - d0), 32'd1);
  endtask

  task automatic check_frags(string tag, logic [YW-1:0] y,
                             logic [XW-1:0] x0, int n);
    logic [XW-1:0] ex;
    check({tag, "_n"}, 32'(got_x.size()), 32'(n));
    ex = x0;
    for (int i = 0; i < n && i < got_x.size(); i++) begin
      check({tag, "_x"}, 32'(got_x[i]), 32'(ex));
      check({tag, "_y"}, 32'(got_y[i]), 32'(y));
      ex = ex + XW'(1);
    end
  endtask

  logic [E-1:0][31:0] vi, vd;

  initial begin
    #2;
    check("rst_ready", 32'(span_ready), 32'd1);
    check("rst_fv",    32'(frag_valid), 32'd0);
    check("rst_latch", 32'(inc_latch),  32'd0);
    check("rst_count", 32'(inc_count),  32'd0);
    check("rst_done",  32'(span_done),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // all edges +1, no increment: four fragments
    vi = {r2f(1.0), r2f(1.0), r2f(1.0)};
    vd = {r2f(0.0), r2f(0.0), r2f(0.0)};
    start_span(10, 5, 4, vi, vd);
    wait_done();
    check_frags("t1", 5, 10, 4);
    check("t1_latch", 32'(n_latch - l0), 32'd1);
    check("t1_count", 32'(n_count - c0), 32'd3);

    // e0 ramps -2..3: x+2 (e0 = +0.0) onward covered
    vi = {r2f(1.0), r2f(1.0), r2f(-2.0)};
    vd = {r2f(1.0), r2f(1.0), r2f(1.0)};
    start_span(100, 7, 6, vi, vd);
    wait_done();
    check_frags("t2", 7, 102, 4);
    check("t2_count", 32'(n_count - c0), 32'd5);

    // -0.0 is uncovered; becomes +1 on the next pixel
    vi = {r2f(1.0), 32'h8000_0000, r2f(1.0)};
    vd = {r2f(0.0), r2f(1.0), r2f(0.0)};
    start_span(50, 9, 2, vi, vd);
    wait_done();
    check_frags("negz", 9, 51, 1);

    // zero length: done right after accept, no latch
    start_span(20, 3, 0, vi, vd);
    check("z_done_t", 32'(span_done), 32'd1);
    wait_done();
    check("z_latch", 32'(n_latch - l0), 32'd0);
    check("z_frags", 32'(got_x.size()), 32'd0);

    // backpressure 1-of-3, slow incrementer, x wraps at 2048
    fr_mode = 1;
    slow = 1;
    vi = {r2f(1.0), r2f(2.0), r2f(0.5)};
    vd = {r2f(0.0), r2f(0.0), r2f(0.0)};
    start_span(2040, 1000, 12, vi, vd);
    wait_done();
    check_frags("bp", 1000, 2040, 12);
    check("bp_count", 32'(n_count - c0), 32'd11);
    fr_mode = 0;
    slow = 0;

    // convex: e0 = 1,0,-1,...
    vi = {r2f(1.0), r2f(1.0), r2f(1.0)};
    vd = {r2f(0.0), r2f(0.0), r2f(-1.0)};
    start_span(300, 2, 8, vi, vd);
    wait_done();
    check_frags("cvx", 2, 300, 2);
`ifdef SAPH_WALKER_EARLY_EXIT_EN
    check("cvx_count", 32'(n_count - c0), 32'd2);
`else
    check("cvx_count", 32'(n_count - c0), 32'd7);
`endif

    // reset while a fragment is stalled
    fr_mode = 2;
    vi = {r2f(1.0), r2f(1.0), r2f(1.0)};
    vd = {r2f(0.0), r2f(0.0), r2f(0.0)};
    start_span(400, 4, 5, vi, vd);
    begin
      int t = 0;
      while (!frag_valid && t < 50) begin @(negedge clk); t++; end
    end
    check("mr_fv_pre", 32'(frag_valid), 32'd1);
    #2 rst_n = 0;
    #1;
    check("mr_fv", 32'(frag_valid), 32'd0);
    check("mr_ready", 32'(span_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    fr_mode = 0;
    @(negedge clk);
    start_span(7, 8, 3, vi, vd);
    wait_done();
    check_frags("mr", 8, 7, 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
